nibble_serial_adder: RTL and testbench

- Sequencer that sits directly in front of a 4-bit full adder (fa4_inst or fa4_mbit) and directly consumes what that adder produces.
- Accepts a wide operand pair via a valid/ready handshake.
- Feeds the adder one 4-bit slice per clock, LSB nibble first, and registers the carry between slices.
- Assembles the full sum and carry-out, then presents them on a valid/ready output.
- Lets the team build N×4-bit additions from a single 4-bit adder instance.

---
 rtl/nibble_serial_adder.sv | 164 ++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one external 4-bit full adder: operands are fed one nibble per
// clock, LSB first, with the inter-slice carry registered between slices.
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_ci,
    output logic [3:0]             fa_a,
    output logic [3:0]             fa_b,
    output logic                   fa_ci,
    input  logic [3:0]             fa_s,
    input  logic                   fa_co,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_co
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [W-1:0]   sum_q, sum_d;
    logic [W-1:0]   out_sum_q, out_sum_d;
    logic           out_co_q, out_co_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;
    logic [3:0]     fa_a_q, fa_a_d;
    logic [3:0]     fa_b_q, fa_b_d;
    logic           fa_ci_q, fa_ci_d;

    logic           last_slice;
    logic [CW-1:0]  cnt_inc;

    function automatic logic [3:0] nibble_of(input logic [W-1:0] v, input logic [CW-1:0] idx);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (CW'(i) == idx) r = v[4*i +: 4];
        end
        return r;
    endfunction

    // The adder inputs are loaded one edge ahead, so fa_* come straight from flops and
    // fa_ci_q also serves as the carry held between slices.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        sum_d       = sum_q;
        out_sum_d   = out_sum_q;
        out_co_d    = out_co_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        fa_a_d      = fa_a_q;
        fa_b_d      = fa_b_q;
        fa_ci_d     = fa_ci_q;
        last_slice  = (cnt_q == CW'(NIBBLES - 1));
        cnt_inc     = cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    opa_d      = in_a;
                    opb_d      = in_b;
                    cnt_d      = '0;
                    fa_a_d     = in_a[3:0];
                    fa_b_d     = in_b[3:0];
                    fa_ci_d    = in_ci;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (CW'(i) == cnt_q) sum_d[4*i +: 4] = fa_s;
                end
                cnt_d = cnt_inc;
                if (last_slice) begin
                    out_sum_d   = sum_d;
                    out_co_d    = fa_co;
                    out_valid_d = 1'b1;
                    fa_a_d      = '0;
                    fa_b_d      = '0;
                    fa_ci_d     = 1'b0;
                    state_d     = DONE;
                end else begin
                    fa_a_d  = nibble_of(opa_q, cnt_inc);
                    fa_b_d  = nibble_of(opb_q, cnt_inc);
                    fa_ci_d = fa_co;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                fa_a_d      = '0;
                fa_b_d      = '0;
                fa_ci_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            sum_q       <= '0;
            out_sum_q   <= '0;
            out_co_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fa_a_q      <= '0;
            fa_b_q      <= '0;
            fa_ci_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sum_q       <= sum_d;
            out_sum_q   <= out_sum_d;
            out_co_q    <= out_co_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            fa_a_q      <= fa_a_d;
            fa_b_q      <= fa_b_d;
            fa_ci_q     <= fa_ci_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_co    = out_co_q;
    assign fa_a      = fa_a_q;
    assign fa_b      = fa_b_q;
    assign fa_ci     = fa_ci_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder with a behavioural 4-bit adder attached to the fa_* ports;
// results are compared against plain wide arithmetic on the operands.
module tb_nibble_serial_adder;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_ci;
    logic [3:0]    fa_a;
    logic [3:0]    fa_b;
    logic          fa_ci;
    logic [3:0]    fa_s;
    logic          fa_co;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_co;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    // Stand-in for the external 4-bit full adder
    logic [4:0] fa_full;
    assign fa_full = {1'b0, fa_a} + {1'b0, fa_b} + {4'b0000, fa_ci};
    assign fa_s    = fa_full[3:0];
    assign fa_co   = fa_full[4];

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_ci     (fa_ci),
        .fa_s      (fa_s),
        .fa_co     (fa_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    // Carry entering slice k is bit 4k of the sum of the operands' low 4k bits.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int k);
        logic [W:0] mask;
        logic [W:0] s;
        if (k == 0) return ci;
        mask = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1;
        s = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {{W{1'b0}}, ci};
        return s[4*k];
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] exp;
        int unsigned waited;
        exp = ref_sum(a, b, ci);
        @(negedge clk);
        in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1; out_ready = 1'b1;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom); in_ci = 1'($urandom);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            check($sformatf("%s_fa_a%0d", tag, k), {28'd0, fa_a}, {28'd0, a[4*k +: 4]});
            check($sformatf("%s_fa_b%0d", tag, k), {28'd0, fa_b}, {28'd0, b[4*k +: 4]});
            check($sformatf("%s_fa_ci%0d", tag, k), {31'd0, fa_ci}, {31'd0, carry_into(a, b, ci, k)});
            check($sformatf("%s_busy%0d", tag, k), {30'd0, in_ready, out_valid}, 32'd0);
        end
        @(negedge clk);
        check({tag, "_latency"}, {31'd0, out_valid}, 32'd1);
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_sum"}, {16'd0, out_sum}, {16'd0, exp[W-1:0]});
        check({tag, "_co"}, {31'd0, out_co}, {31'd0, exp[W]});
        @(negedge clk);
        check({tag, "_idle_flags"}, {30'd0, out_valid, in_ready}, 32'd1);
        check({tag, "_sum_held"}, {16'd0, out_sum}, {16'd0, exp[W-1:0]});
    endtask

    initial begin
        logic [W:0] exp;
        logic [W:0] q[$];
        int unsigned waited;
        int unsigned accepted;
        int last_c;
        logic seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_ci = 1'b0;
        #3;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("rst_out_co", {31'd0, out_co}, 32'd0);
        check("rst_fa", {23'd0, fa_a, fa_b, fa_ci}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("basic", 16'h1234, 16'h4321, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
        run_op("ones_ci", 16'hFFFF, 16'hFFFF, 1'b1);
        run_op("zero_ci", 16'h0000, 16'h0000, 1'b1);
        for (int r = 0; r < 4; r++)
            run_op($sformatf("rand%0d", r), W'($urandom), W'($urandom), 1'($urandom));

        // Backpressure: result held while new operands wait at the input
        @(negedge clk);
        in_a = 16'h0A5C; in_b = 16'h1111; in_ci = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_a = W'($urandom); in_b = W'($urandom);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 20);
        check("bp_valid_rise", {31'd0, out_valid}, 32'd1);
        for (int h = 0; h < 5; h++) begin
            check($sformatf("bp_hold_valid%0d", h), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_hold_sum%0d", h), {16'd0, out_sum}, 32'h1B6D);
            check($sformatf("bp_hold_ready%0d", h), {31'd0, in_ready}, 32'd0);
            in_a = W'($urandom); in_b = W'($urandom); in_ci = 1'($urandom);
            if (h == 4) begin
                in_a = 16'h2222; in_b = 16'h3333; in_ci = 1'b0; out_ready = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        check("bp_idle_flags", {30'd0, out_valid, in_ready}, 32'd1);
        check("bp_idle_sum", {16'd0, out_sum}, 32'h1B6D);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_new_accept", {23'd0, in_ready, fa_a, fa_b}, 32'h023);
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("bp_new_sum", {15'd0, out_co, out_sum}, 32'h05555);

        // Asynchronous reset while the third slice is in the adder
        @(negedge clk);
        @(negedge clk);
        in_a = 16'h8888; in_b = 16'h8888; in_ci = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_pre_fa", {23'd0, fa_a, fa_b, fa_ci}, {23'd0, 4'h8, 4'h8, 1'b1});
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_flags", {30'd0, out_valid, in_ready}, 32'd1);
        check("mid_rst_fa", {23'd0, fa_a, fa_b, fa_ci}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mid_no_stale_valid", {31'd0, seen}, 32'd0);
        run_op("post_rst", 16'h0001, 16'h0002, 1'b0);

        // Back-to-back with constant in_valid/out_ready
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        in_a = W'($urandom); in_b = W'($urandom); in_ci = 1'($urandom);
        accepted = 0;
        last_c = 0;
        for (int c = 0; c < 200 && !(accepted == 20 && q.size() == 0); c++) begin
            if (c != 0) @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("b2b_spurious", 32'd1, 32'd0);
                end else begin
                    exp = q.pop_front();
                    check("b2b_sum", {16'd0, out_sum}, {16'd0, exp[W-1:0]});
                    check("b2b_co", {31'd0, out_co}, {31'd0, exp[W]});
                end
            end
            if (in_ready && in_valid) begin
                q.push_back(ref_sum(in_a, in_b, in_ci));
                if (accepted > 0) check("b2b_interval", 32'(c - last_c), 32'd6);
                last_c = c;
                accepted++;
            end
            @(posedge clk);
            #1;
            if (accepted == 20) in_valid = 1'b0;
            else begin
                in_a = W'($urandom); in_b = W'($urandom); in_ci = 1'($urandom);
            end
        end
        check("b2b_complete", {27'd0, accepted[4:0]}, 32'd20);
        check("b2b_drained", 32'(q.size()), 32'd0);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
